// File: rtl/sprite_compositor.sv
// Two-stage sprite compositor: player, N_CARS cars and three safe bands to 3-bit VGA colour,
// with sprite positions shadowed at vblank start and a once-per-frame player/car collision report.
module sprite_compositor #(
  parameter int N_CARS    = 8,
  parameter int COORD_W   = 10,
  parameter int H_DISPLAY = 640,
  parameter int V_DISPLAY = 480,
  parameter int PLAYER_W  = 16,
  parameter int PLAYER_H  = 16,
  parameter int CAR_W     = 32,
  parameter int CAR_H     = 16,
  parameter int SAFE_X    = 0,
  parameter int SAFE_W    = 640,
  parameter int SAFE_H    = 32,
  parameter int SAFE_Y0   = 0,
  parameter int SAFE_Y1   = 224,
  parameter int SAFE_Y2   = 448,
  localparam int IDX_W    = (N_CARS > 1) ? $clog2(N_CARS) : 1
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [COORD_W-1:0]          h_count,
  input  logic [COORD_W-1:0]          v_count,
  input  logic [COORD_W-1:0]          player_x,
  input  logic [COORD_W-1:0]          player_y,
  input  logic [N_CARS*COORD_W-1:0]   car_x,
  input  logic [N_CARS*COORD_W-1:0]   car_y,
  input  logic [N_CARS-1:0]           car_en,
  output logic                        VGA_R2,
  output logic                        VGA_G2,
  output logic                        VGA_B2,
  output logic                        collision,
  output logic [IDX_W-1:0]            hit_car_idx,
  output logic                        frame_done
);

  localparam logic [COORD_W:0]   PW  = (COORD_W+1)'(PLAYER_W);
  localparam logic [COORD_W:0]   PH  = (COORD_W+1)'(PLAYER_H);
  localparam logic [COORD_W:0]   CW  = (COORD_W+1)'(CAR_W);
  localparam logic [COORD_W:0]   CH  = (COORD_W+1)'(CAR_H);
  localparam logic [COORD_W:0]   SW  = (COORD_W+1)'(SAFE_W);
  localparam logic [COORD_W:0]   SH  = (COORD_W+1)'(SAFE_H);
  localparam logic [COORD_W:0]   HD  = (COORD_W+1)'(H_DISPLAY);
  localparam logic [COORD_W:0]   VD  = (COORD_W+1)'(V_DISPLAY);
  localparam logic [COORD_W-1:0] SX  = COORD_W'(SAFE_X);
  localparam logic [COORD_W-1:0] SY0 = COORD_W'(SAFE_Y0);
  localparam logic [COORD_W-1:0] SY1 = COORD_W'(SAFE_Y1);
  localparam logic [COORD_W-1:0] SY2 = COORD_W'(SAFE_Y2);

  // Extra top bit keeps lo+size from wrapping back to column/row 0 at the screen edge.
  function automatic logic in_span(input logic [COORD_W-1:0] pos,
                                   input logic [COORD_W-1:0] lo,
                                   input logic [COORD_W:0]   size);
    logic [COORD_W:0] p;
    logic [COORD_W:0] l;
    p = {1'b0, pos};
    l = {1'b0, lo};
    return (p >= l) && (p < l + size);
  endfunction

  function automatic logic [IDX_W-1:0] lowest_idx(input logic [N_CARS-1:0] hits);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int i = N_CARS - 1; i >= 0; i--)
      if (hits[i]) idx = IDX_W'(i);
    return idx;
  endfunction

  logic [COORD_W-1:0]        sh_player_x, sh_player_y;
  logic [N_CARS*COORD_W-1:0] sh_car_x, sh_car_y;
  logic [N_CARS-1:0]         sh_car_en;
  logic                      armed;
  logic                      latch_evt, latch_p1;

  logic                      vis_c, player_hit_c, safe_hit_c;
  logic [N_CARS-1:0]         car_hit_c;

  logic                      vis_p1, player_hit_p1, safe_hit_p1;
  logic [N_CARS-1:0]         car_hit_p1;
  logic [2:0]                rgb_p2;

  logic                      acc_flag;
  logic [IDX_W-1:0]          acc_idx;

  assign latch_evt = (h_count == '0) && ({1'b0, v_count} == VD);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sh_player_x <= '0;
      sh_player_y <= '0;
      sh_car_x    <= '0;
      sh_car_y    <= '0;
      sh_car_en   <= '0;
      armed       <= 1'b0;
      latch_p1    <= 1'b0;
    end else begin
      latch_p1 <= latch_evt;
      if (latch_evt) begin
        sh_player_x <= player_x;
        sh_player_y <= player_y;
        sh_car_x    <= car_x;
        sh_car_y    <= car_y;
        sh_car_en   <= car_en;
        armed       <= 1'b1;
      end
    end
  end

  // The player is held off until the first latch so reset-zero shadows draw nothing.
  always_comb begin
    vis_c        = ({1'b0, h_count} < HD) && ({1'b0, v_count} < VD);
    player_hit_c = armed && in_span(h_count, sh_player_x, PW) && in_span(v_count, sh_player_y, PH);
    safe_hit_c   = in_span(h_count, SX, SW) &&
                   (in_span(v_count, SY0, SH) || in_span(v_count, SY1, SH) || in_span(v_count, SY2, SH));
    car_hit_c    = '0;
    for (int i = 0; i < N_CARS; i++)
      car_hit_c[i] = sh_car_en[i] &&
                     in_span(h_count, sh_car_x[i*COORD_W +: COORD_W], CW) &&
                     in_span(v_count, sh_car_y[i*COORD_W +: COORD_W], CH);
  end

  // Stage 1: registered hit tests
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      vis_p1        <= 1'b0;
      player_hit_p1 <= 1'b0;
      car_hit_p1    <= '0;
      safe_hit_p1   <= 1'b0;
    end else begin
      vis_p1        <= vis_c;
      player_hit_p1 <= player_hit_c;
      car_hit_p1    <= car_hit_c;
      safe_hit_p1   <= safe_hit_c;
    end
  end

  // Stage 2: priority colour select
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N)              rgb_p2 <= 3'b000;
    else if (!vis_p1)        rgb_p2 <= 3'b000;
    else if (player_hit_p1)  rgb_p2 <= 3'b010;
    else if (|car_hit_p1)    rgb_p2 <= 3'b100;
    else if (safe_hit_p1)    rgb_p2 <= 3'b111;
    else                     rgb_p2 <= 3'b000;
  end

  assign VGA_R2 = rgb_p2[2];
  assign VGA_G2 = rgb_p2[1];
  assign VGA_B2 = rgb_p2[0];

  // Report/clear runs while the latch pixel sits in stage 1 (vis=0), so it never meets a set.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      acc_flag    <= 1'b0;
      acc_idx     <= '0;
      collision   <= 1'b0;
      hit_car_idx <= '0;
      frame_done  <= 1'b0;
    end else if (latch_p1) begin
      collision   <= acc_flag;
      hit_car_idx <= acc_idx;
      frame_done  <= 1'b1;
      acc_flag    <= 1'b0;
      acc_idx     <= '0;
    end else begin
      frame_done <= 1'b0;
      if (vis_p1 && player_hit_p1 && (|car_hit_p1) && !acc_flag) begin
        acc_flag <= 1'b1;
        acc_idx  <= lowest_idx(car_hit_p1);
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: safe bands, sprite colours, latching,
// collision reporting, screen-edge clipping, pipeline throughput and reset.
module tb_sprite_compositor;

  localparam int N_CARS  = 8;
  localparam int COORD_W = 10;
  localparam int IDX_W   = 3;

  logic                      CLK = 1'b0;
  logic                      RST_N = 1'b1;
  logic [COORD_W-1:0]        h_count = '0;
  logic [COORD_W-1:0]        v_count = 10'd10;
  logic [COORD_W-1:0]        player_x = '0;
  logic [COORD_W-1:0]        player_y = '0;
  logic [N_CARS*COORD_W-1:0] car_x = '0;
  logic [N_CARS*COORD_W-1:0] car_y = '0;
  logic [N_CARS-1:0]         car_en = '0;
  logic                      VGA_R2, VGA_G2, VGA_B2;
  logic                      collision;
  logic [IDX_W-1:0]          hit_car_idx;
  logic                      frame_done;

  int n_cmp = 0;
  int n_err = 0;
  int fd_count = 0;

  sprite_compositor dut (
    .CLK(CLK), .RST_N(RST_N), .h_count(h_count), .v_count(v_count),
    .player_x(player_x), .player_y(player_y), .car_x(car_x), .car_y(car_y),
    .car_en(car_en), .VGA_R2(VGA_R2), .VGA_G2(VGA_G2), .VGA_B2(VGA_B2),
    .collision(collision), .hit_car_idx(hit_car_idx), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (frame_done === 1'b1) fd_count++;

  task automatic set_car(input int i, input int x, input int y, input logic en);
    logic [31:0] xv, yv;
    xv = x; yv = y;
    car_x[i*COORD_W +: COORD_W] = xv[COORD_W-1:0];
    car_y[i*COORD_W +: COORD_W] = yv[COORD_W-1:0];
    car_en[i] = en;
  endtask

  // Presents one pixel and returns its colour two clocks later.
  task automatic sample_rgb(input int h, input int v, output logic [2:0] rgb);
    @(negedge CLK);
    h_count = h[COORD_W-1:0];
    v_count = v[COORD_W-1:0];
    @(posedge CLK);
    @(negedge CLK);
    @(posedge CLK);
    #1 rgb = {VGA_R2, VGA_G2, VGA_B2};
  endtask

  task automatic do_latch(output logic fd1, output logic fd2, output logic col,
                          output logic [IDX_W-1:0] idx);
    @(negedge CLK);
    h_count = 10'd0; v_count = 10'd480;
    @(posedge CLK);
    @(negedge CLK);
    h_count = 10'd1;
    @(posedge CLK);
    #1 fd1 = frame_done; col = collision; idx = hit_car_idx;
    @(posedge CLK);
    #1 fd2 = frame_done;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({VGA_R2, VGA_G2, VGA_B2, collision, hit_car_idx, frame_done} !== 8'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got %b, want 00000000",
               {VGA_R2, VGA_G2, VGA_B2, collision, hit_car_idx, frame_done});
    end
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
  endtask

  task automatic test_safe_bands();
    int hs[12] = '{5, 5, 5, 5, 5, 5, 639, 5, 640, 0, 100, 300};
    int vs[12] = '{0, 31, 32, 224, 255, 256, 479, 447, 10, 0, 300, 300};
    int ex[12] = '{7, 7, 0, 7, 7, 0, 7, 0, 0, 7, 0, 0};
    logic [2:0] rgb;
    int fd0;
    player_x = 10'd100; player_y = 10'd300;
    set_car(0, 300, 300, 1'b1);
    fd0 = fd_count;
    for (int k = 0; k < 12; k++) begin
      sample_rgb(hs[k], vs[k], rgb);
      n_cmp++;
      if (rgb !== 3'(ex[k])) begin
        n_err++;
        $display("FAIL safe_band(%0d,%0d): got %b, want %b", hs[k], vs[k], rgb, 3'(ex[k]));
      end
    end
    n_cmp++;
    if (fd_count !== fd0) begin
      n_err++;
      $display("FAIL no_latch_frame_done: got %0d pulses, want 0", fd_count - fd0);
    end
  endtask

  task automatic test_basic_draw();
    int hs[8] = '{100, 115, 116, 300, 331, 332, 300, 99};
    int vs[8] = '{300, 315, 300, 300, 315, 300, 316, 300};
    int ex[8] = '{2, 2, 0, 4, 4, 0, 0, 0};
    logic [2:0] rgb;
    logic fd1, fd2, col;
    logic [IDX_W-1:0] idx;
    do_latch(fd1, fd2, col, idx);
    n_cmp++;
    if ({fd1, fd2, col} !== 3'b100) begin
      n_err++;
      $display("FAIL first_latch fd1/fd2/col: got %b, want 100", {fd1, fd2, col});
    end
    for (int k = 0; k < 8; k++) begin
      sample_rgb(hs[k], vs[k], rgb);
      n_cmp++;
      if (rgb !== 3'(ex[k])) begin
        n_err++;
        $display("FAIL basic_draw(%0d,%0d): got %b, want %b", hs[k], vs[k], rgb, 3'(ex[k]));
      end
    end
  endtask

  task automatic test_collision();
    logic [2:0] rgb;
    logic fd1, fd2, col;
    logic [IDX_W-1:0] idx;
    set_car(0, 300, 300, 1'b0);
    set_car(2, 96, 296, 1'b1);
    set_car(5, 100, 300, 1'b1);
    do_latch(fd1, fd2, col, idx);
    n_cmp++;
    if ({fd1, fd2, col, idx} !== 6'b100000) begin
      n_err++;
      $display("FAIL basic_frame_report fd1/fd2/col/idx: got %b, want 100000", {fd1, fd2, col, idx});
    end
    sample_rgb(96, 296, rgb);
    n_cmp++;
    if (rgb !== 3'b100) begin n_err++; $display("FAIL car2_red: got %b, want 100", rgb); end
    sample_rgb(100, 300, rgb);
    n_cmp++;
    if (rgb !== 3'b010) begin n_err++; $display("FAIL player_over_cars: got %b, want 010", rgb); end
    sample_rgb(100, 312, rgb);
    n_cmp++;
    if (rgb !== 3'b010) begin n_err++; $display("FAIL player_over_car5: got %b, want 010", rgb); end
    set_car(2, 500, 100, 1'b1);
    set_car(5, 500, 150, 1'b1);
    do_latch(fd1, fd2, col, idx);
    n_cmp++;
    if ({fd1, fd2, col, idx} !== 6'b101010) begin
      n_err++;
      $display("FAIL collision_report fd1/fd2/col/idx: got %b, want 101010", {fd1, fd2, col, idx});
    end
    sample_rgb(100, 300, rgb);
    n_cmp++;
    if (rgb !== 3'b010) begin n_err++; $display("FAIL player_after_move: got %b, want 010", rgb); end
    do_latch(fd1, fd2, col, idx);
    n_cmp++;
    if ({fd1, col, idx} !== 5'b10000) begin
      n_err++;
      $display("FAIL moved_away_report fd1/col/idx: got %b, want 10000", {fd1, col, idx});
    end
  endtask

  task automatic test_disabled_cars();
    int hs[4] = '{96, 100, 100, 128};
    int vs[4] = '{296, 300, 312, 300};
    int ex[4] = '{0, 2, 2, 0};
    logic [2:0] rgb;
    logic fd1, fd2, col;
    logic [IDX_W-1:0] idx;
    set_car(2, 96, 296, 1'b0);
    set_car(5, 100, 300, 1'b0);
    do_latch(fd1, fd2, col, idx);
    for (int k = 0; k < 4; k++) begin
      sample_rgb(hs[k], vs[k], rgb);
      n_cmp++;
      if (rgb !== 3'(ex[k])) begin
        n_err++;
        $display("FAIL disabled_car(%0d,%0d): got %b, want %b", hs[k], vs[k], rgb, 3'(ex[k]));
      end
    end
    do_latch(fd1, fd2, col, idx);
    n_cmp++;
    if ({fd1, col} !== 2'b10) begin
      n_err++;
      $display("FAIL disabled_report fd1/col: got %b, want 10", {fd1, col});
    end
  endtask

  task automatic test_screen_edge();
    int hs[6] = '{629, 630, 639, 0, 1, 640};
    int vs[6] = '{100, 100, 115, 100, 115, 100};
    int ex[6] = '{0, 4, 4, 0, 0, 0};
    logic [2:0] rgb;
    logic fd1, fd2, col;
    logic [IDX_W-1:0] idx;
    player_x = 10'd300; player_y = 10'd400;
    set_car(0, 630, 100, 1'b1);
    do_latch(fd1, fd2, col, idx);
    for (int k = 0; k < 6; k++) begin
      sample_rgb(hs[k], vs[k], rgb);
      n_cmp++;
      if (rgb !== 3'(ex[k])) begin
        n_err++;
        $display("FAIL edge_clip(%0d,%0d): got %b, want %b", hs[k], vs[k], rgb, 3'(ex[k]));
      end
    end
  endtask

  task automatic test_back_to_back();
    int hs[7] = '{628, 629, 630, 631, 300, 0, 0};
    int vs[7] = '{100, 100, 100, 100, 400, 0, 40};
    int ex[7] = '{0, 0, 4, 4, 2, 7, 0};
    logic [2:0] rgb;
    for (int k = 0; k <= 7; k++) begin
      @(negedge CLK);
      if (k < 7) begin
        h_count = hs[k][COORD_W-1:0];
        v_count = vs[k][COORD_W-1:0];
      end
      @(posedge CLK);
      #1 rgb = {VGA_R2, VGA_G2, VGA_B2};
      if (k >= 1) begin
        n_cmp++;
        if (rgb !== 3'(ex[k-1])) begin
          n_err++;
          $display("FAIL stream[%0d]: got %b, want %b", k - 1, rgb, 3'(ex[k-1]));
        end
      end
    end
  endtask

  task automatic test_midframe_and_reset();
    logic [2:0] rgb;
    logic fd1, fd2, col;
    logic [IDX_W-1:0] idx;
    int fd0;
    player_x = 10'd100; player_y = 10'd300;
    set_car(0, 630, 100, 1'b0);
    set_car(1, 100, 300, 1'b1);
    do_latch(fd1, fd2, col, idx);
    sample_rgb(100, 300, rgb);
    do_latch(fd1, fd2, col, idx);
    n_cmp++;
    if ({fd1, col, idx} !== 5'b11001) begin
      n_err++;
      $display("FAIL car1_report fd1/col/idx: got %b, want 11001", {fd1, col, idx});
    end
    @(negedge CLK);
    h_count = 10'd50; v_count = 10'd200;
    player_x = 10'd200;
    sample_rgb(100, 300, rgb);
    n_cmp++;
    if (rgb !== 3'b010) begin n_err++; $display("FAIL midframe_old_player: got %b, want 010", rgb); end
    sample_rgb(200, 300, rgb);
    n_cmp++;
    if (rgb !== 3'b000) begin n_err++; $display("FAIL midframe_new_player: got %b, want 000", rgb); end
    sample_rgb(100, 300, rgb);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    n_cmp++;
    if ({VGA_R2, VGA_G2, VGA_B2, collision, hit_car_idx, frame_done} !== 8'd0) begin
      n_err++;
      $display("FAIL midframe_reset: got %b, want 00000000",
               {VGA_R2, VGA_G2, VGA_B2, collision, hit_car_idx, frame_done});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    fd0 = fd_count;
    sample_rgb(100, 300, rgb);
    n_cmp++;
    if (rgb !== 3'b000) begin n_err++; $display("FAIL post_reset_sprites: got %b, want 000", rgb); end
    sample_rgb(10, 5, rgb);
    n_cmp++;
    if (rgb !== 3'b111) begin n_err++; $display("FAIL post_reset_band: got %b, want 111", rgb); end
    n_cmp++;
    if (fd_count !== fd0) begin
      n_err++;
      $display("FAIL post_reset_frame_done: got %0d pulses, want 0", fd_count - fd0);
    end
    do_latch(fd1, fd2, col, idx);
    n_cmp++;
    if ({fd1, fd2, col, idx} !== 6'b100000) begin
      n_err++;
      $display("FAIL post_reset_report fd1/fd2/col/idx: got %b, want 100000", {fd1, fd2, col, idx});
    end
    sample_rgb(200, 300, rgb);
    n_cmp++;
    if (rgb !== 3'b010) begin n_err++; $display("FAIL relatched_player: got %b, want 010", rgb); end
    sample_rgb(100, 300, rgb);
    n_cmp++;
    if (rgb !== 3'b100) begin n_err++; $display("FAIL relatched_car1: got %b, want 100", rgb); end
  endtask

  initial begin
    test_reset();
    test_safe_bands();
    test_basic_draw();
    test_collision();
    test_disabled_cars();
    test_screen_edge();
    test_back_to_back();
    test_midframe_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
